// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the OpenMIPS pipeline stall/flush controller.
// Holds the stall vector encodings, stall bit indices, controller state encoding
// and the default multi-cycle length field width.
package pipe_ctrl_pkg;

    // Default width of the multi-cycle length field
    localparam int MC_LEN_W = 6;

    // Stall vector bit indices: one hold bit per pipeline register
    localparam int STALL_PC_BIT  = 0;
    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_ID_BIT  = 2;
    localparam int STALL_EX_BIT  = 3;
    localparam int STALL_MEM_BIT = 4;
    localparam int STALL_WB_BIT  = 5;

    // Stall vector encodings
    localparam logic [5:0] STALL_NONE = 6'b000000;  // pipeline flows
    localparam logic [5:0] STALL_ID   = 6'b000111;  // hold pc/if/id, bubble into EX
    localparam logic [5:0] STALL_EX   = 6'b001111;  // hold pc/if/id/ex, bubble into MEM

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MC_BUSY = 2'b01,
        ST_FLUSH   = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: pair of saturating stall-cycle counters with synchronous clear.
// Only instantiated by pipe_ctrl when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              id_inc,
    input  logic              ex_inc,
    output logic [PERF_W-1:0] id_cnt,
    output logic [PERF_W-1:0] ex_cnt
);

    import pipe_ctrl_pkg::*;

    // ID-only stall cycle counter: clear wins over increment, holds at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            id_cnt <= '0;
        end else if (id_inc && (id_cnt != '1)) begin
            id_cnt <= id_cnt + PERF_W'(1);
        end
    end

    // EX stall cycle counter: clear wins over increment, holds at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ex_cnt <= '0;
        end else if (ex_inc && (ex_cnt != '1)) begin
            ex_cnt <= ex_cnt + PERF_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage OpenMIPS pipeline.
// Merges the ID load-use stall, multi-cycle EX occupancy and MEM exception
// flushes into one stall vector, a flush strobe and a redirect PC. The stall,
// flush and redirect outputs are combinational so a request acts in its own cycle.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall perf counters.
module pipe_ctrl #(
    parameter int MC_LEN_W = pipe_ctrl_pkg::MC_LEN_W
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int PERF_W   = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_stallreq,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                ex_mc_abort,
    input  logic                exc_req,
    input  logic [31:0]         exc_vec,
    output logic [5:0]          stall_o,
    output logic                flush_o,
    output logic [31:0]         new_pc_o,
    output logic                ex_mc_busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    input  logic                perf_clr,
    output logic [PERF_W-1:0]   perf_id_stall_o,
    output logic [PERF_W-1:0]   perf_ex_stall_o
`endif
);

    import pipe_ctrl_pkg::*;

    state_t              state;
    logic [MC_LEN_W-1:0] cnt;

    // Same-cycle stall/flush decision from the inputs and the registered state
    always_comb begin
        stall_o  = STALL_NONE;
        flush_o  = 1'b0;
        new_pc_o = 32'h0000_0000;
        if (!rst) begin
            unique case (state)
                ST_IDLE: begin
                    // Flush beats a simultaneous start; a zero-length start is no stall
                    if (exc_req) begin
                        flush_o  = 1'b1;
                        new_pc_o = exc_vec;
                    end else if (ex_mc_start && (ex_mc_len != '0)) begin
                        stall_o = STALL_EX;
                    end else if (id_stallreq) begin
                        stall_o = STALL_ID;
                    end
                end
                ST_MC_BUSY: begin
                    // EX occupancy subsumes any ID hazard unless flushed or aborted
                    if (exc_req) begin
                        flush_o  = 1'b1;
                        new_pc_o = exc_vec;
                    end else if (ex_mc_abort) begin
                        stall_o = id_stallreq ? STALL_ID : STALL_NONE;
                    end else begin
                        stall_o = STALL_EX;
                    end
                end
                ST_FLUSH: begin
                    // Requests from flushed instructions are dropped; a new exception re-flushes
                    if (exc_req) begin
                        flush_o  = 1'b1;
                        new_pc_o = exc_vec;
                    end
                end
                default: begin
                    stall_o = STALL_NONE;
                end
            endcase
        end
    end

    // Controller FSM: state, multi-cycle countdown and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ex_mc_busy_o <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (exc_req) begin
                        state        <= ST_FLUSH;
                        cnt          <= '0;
                        ex_mc_busy_o <= 1'b0;
                    end else if (ex_mc_start && (ex_mc_len > MC_LEN_W'(1))) begin
                        // Start cycle is the first stall cycle, so N-1 busy cycles remain
                        state        <= ST_MC_BUSY;
                        cnt          <= ex_mc_len - MC_LEN_W'(1);
                        ex_mc_busy_o <= 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    if (exc_req) begin
                        state        <= ST_FLUSH;
                        cnt          <= '0;
                        ex_mc_busy_o <= 1'b0;
                    end else if (ex_mc_abort || (cnt <= MC_LEN_W'(1))) begin
                        state        <= ST_IDLE;
                        cnt          <= '0;
                        ex_mc_busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - MC_LEN_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state        <= exc_req ? ST_FLUSH : ST_IDLE;
                    cnt          <= '0;
                    ex_mc_busy_o <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    cnt          <= '0;
                    ex_mc_busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic perf_id_inc;
    logic perf_ex_inc;

    assign perf_id_inc = (stall_o == STALL_ID);
    assign perf_ex_inc = stall_o[STALL_EX_BIT];

    pipe_ctrl_perf #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk    (clk),
        .rst    (rst),
        .clr    (perf_clr),
        .id_inc (perf_id_inc),
        .ex_inc (perf_ex_inc),
        .id_cnt (perf_id_stall_o),
        .ex_cnt (perf_ex_stall_o)
    );
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage OpenMIPS pipeline. It merges the ID-stage load-use stall request, multi-cycle EX operations (DIV, MADD/MSUB) and MEM-stage exception flushes into one per-stage stall vector, a flush strobe and a redirect PC. It drives the hold/bubble inputs of pc_reg, if_id, id_ex, ex_mem and mem_wb, and sequences multi-cycle EX occupancy with an internal counter FSM.

## Interface
- MC_LEN_W, 6: width of the multi-cycle length field.
- PERF_W, 32: width of the stall performance counters (present only with the macro).
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- id_stallreq  in  1  level; ID detected a load-use hazard this cycle.
- ex_mc_start  in  1  pulse; EX begins a multi-cycle op this cycle.
- ex_mc_len  in  MC_LEN_W  total stall cycles for that op, including the start cycle; 0 means no stall.
- ex_mc_abort  in  1  pulse; EX cancels the running multi-cycle op.
- exc_req  in  1  pulse; MEM requests a pipeline flush.
- exc_vec  in  32  redirect PC for exc_req.
- stall_o  out  6  hold bits: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
- flush_o  out  1  flush all pipeline registers this cycle.
- new_pc_o  out  32  redirect PC, valid when flush_o=1.
- ex_mc_busy_o  out  1  registered; FSM is in MC_BUSY.
- perf_clr  in  1  (macro only) synchronous counter clear.
- perf_id_stall_o  out  PERF_W  (macro only) ID-only stall cycles.
- perf_ex_stall_o  out  PERF_W  (macro only) EX stall cycles.

## Operation
- Stall encodings: NONE = 6'b000000, ID = 6'b000111 (bubble into EX), EX = 6'b001111 (bubble into MEM).
- Priority inside one cycle: exc_req > EX stall > ID stall.
- FSM states: IDLE, MC_BUSY, FLUSH. Counter cnt is MC_LEN_W bits.
- IDLE:
  - exc_req: flush_o=1, new_pc_o=exc_vec, stall_o=NONE; next state FLUSH.
  - ex_mc_start with ex_mc_len=N≥1: stall_o=EX this cycle. If N=1, stay IDLE. If N≥2, go to MC_BUSY with cnt=N−1.
  - ex_mc_start with ex_mc_len=0: the start is ignored.
  - id_stallreq alone: stall_o=ID.
- MC_BUSY:
  - stall_o=EX; cnt decrements each cycle; when cnt=1, next state is IDLE. MC_BUSY therefore lasts N−1 cycles, giving N stall cycles in total.
  - id_stallreq is subsumed by the EX stall.
  - ex_mc_start is ignored.
  - ex_mc_abort: stall_o falls to ID or NONE in the same cycle (according to id_stallreq); next state IDLE; cnt cleared.
  - exc_req: handled as in IDLE; cnt cleared; next state FLUSH.
- FLUSH (exactly one cycle):
  - stall_o=NONE, flush_o=0.
  - id_stallreq and ex_mc_start are ignored, because they come from flushed instructions.
  - exc_req is accepted and re-flushes; the state stays FLUSH for one more cycle.
  - Otherwise next state is IDLE.
- new_pc_o=0 whenever flush_o=0.

## Timing
- Reset values (rst=1, sampled at the clock edge): state IDLE, cnt 0, ex_mc_busy_o 0, perf counters 0.
- While rst=1, stall_o, flush_o and new_pc_o are forced to 0 combinationally.
- stall_o, flush_o and new_pc_o are combinational from the inputs and the registered state, with zero-cycle latency. This lets a load-use stall or flush take effect in the same cycle it is requested.
- ex_mc_busy_o goes high one cycle after an accepted start with N≥2, and falls the cycle after the last MC_BUSY cycle.
- exc_req arriving together with ex_mc_start in IDLE: the flush wins and the start is discarded.
- Back-to-back multi-cycle ops: a new ex_mc_start is accepted in the first IDLE cycle after MC_BUSY.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_clr, perf_id_stall_o and perf_ex_stall_o exist.
  - perf_id_stall_o increments on cycles with stall_o=ID; perf_ex_stall_o increments on cycles with stall_o[3]=1.
  - Both counters saturate at all-ones.
  - perf_clr has priority over increment; the cleared value is visible the next cycle.
- PIPE_CTRL_PERF_EN undefined: the perf ports and counters are absent; all other behaviour is identical.

## Structure
- The shared defines file holds:
  - the three stall encodings;
  - the state encodings (IDLE=2'b00, MC_BUSY=2'b01, FLUSH=2'b10);
  - MC_LEN_W;
  - the stall_o bit indices.
- One sub-module, pipe_ctrl_perf: two saturating counters with clear, instantiated only under PIPE_CTRL_PERF_EN.

## Test plan
- id_stallreq=1 for 2 cycles in IDLE -> stall_o=6'b000111 in exactly those 2 cycles; flush_o=0; ex_mc_busy_o=0.
- ex_mc_start with ex_mc_len=5 -> stall_o=6'b001111 for 5 consecutive cycles starting at the start cycle; ex_mc_busy_o high for cycles 2–5; IDLE afterwards. ex_mc_len=1 -> 1 stall cycle, busy never rises. ex_mc_len=0 -> no stall.
- ex_mc_len=20, ex_mc_abort in the 4th cycle -> stall_o=0 in the abort cycle (id_stallreq=0); IDLE next cycle.
- exc_req with exc_vec=32'h0000_0180 during MC_BUSY -> same cycle flush_o=1, new_pc_o=32'h0000_0180, stall_o=0. Next cycle FLUSH ignores id_stallreq=1 (stall_o=0). Then IDLE.
- exc_req and ex_mc_start in the same IDLE cycle; then exc_req again in the FLUSH cycle -> two flush pulses, no stall, ex_mc_busy_o never rises.
- With PIPE_CTRL_PERF_EN: 3 ID-stall cycles plus a 5-cycle EX op -> perf_id_stall_o=3, perf_ex_stall_o=5. Assert perf_clr -> both read 0 on the next cycle. Preload to all-ones -> counters hold at 32'hFFFF_FFFF.
